// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo: show-ahead byte FIFO behind the UART receiver.
// Ports: i_Clock, i_Rst_n (sync, active-low), i_Rx_DV/i_Rx_Byte (write),
//   i_Rd_En (pop), i_Clr_Ovf; o_Data (head or 8'h00), o_Valid, o_Count,
//   o_Full, o_Overflow (sticky drop flag), o_Almost_Full (optional).
// Optional: define UART_RX_FIFO_ALMOST_FULL_EN to add o_Almost_Full
//   (and its AF_LEVEL threshold parameter).
module uart_rx_byte_fifo #(
  parameter int DEPTH = 16
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2
`endif
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_n,
  input  logic                     i_Rx_DV,
  input  logic [7:0]               i_Rx_Byte,
  input  logic                     i_Rd_En,
  input  logic                     i_Clr_Ovf,
  output logic [7:0]               o_Data,
  output logic                     o_Valid,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_Full,
  output logic                     o_Overflow
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                     o_Almost_Full
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_Rd_En && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still
  // accept the incoming byte without dropping it.
  assign w_push  = i_Rx_DV && (!w_full || w_pop);
  assign w_drop  = i_Rx_DV && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge i_Clock) begin
    if (i_Rst_n && w_push) begin
      r_mem[r_wr_ptr] <= i_Rx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (i_Clr_Ovf) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic r_af;

  // Registered from the next count so it lines up with o_Count.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      r_af <= 1'b0;
    end else begin
      r_af <= (w_count_nxt >= CW'(AF_LEVEL));
    end
  end

  assign o_Almost_Full = r_af;
`endif

  assign o_Valid    = !w_empty;
  assign o_Full     = w_full;
  assign o_Count    = r_count;
  assign o_Overflow = r_ovf;
  assign o_Data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// tb_uart_rx_byte_fifo: scoreboard bench for uart_rx_byte_fifo.
// Driver predicts accepted bytes; negedge monitor pops and compares.
module tb_uart_rx_byte_fifo;

  localparam int DEPTH = 16;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       i_Rd_En = 1'b0;
  logic       i_Clr_Ovf = 1'b0;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic [4:0] o_Count;
  logic       o_Full;
  logic       o_Overflow;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic       o_Almost_Full;
`endif

  uart_rx_byte_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_Rx_DV   (i_Rx_DV),
    .i_Rx_Byte (i_Rx_Byte),
    .i_Rd_En   (i_Rd_En),
    .i_Clr_Ovf (i_Clr_Ovf),
    .o_Data    (o_Data),
    .o_Valid   (o_Valid),
    .o_Count   (o_Count),
    .o_Full    (o_Full),
    .o_Overflow(o_Overflow)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .o_Almost_Full(o_Almost_Full)
`endif
  );

  always #5 i_Clock = ~i_Clock;

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         m_count = 0;
  bit         m_ovf = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Monitor: state outputs vs model, popped data vs scoreboard.
  always @(negedge i_Clock) begin
    if (mon_en) begin
      chk("count", int'(o_Count), m_count);
      chk("valid", int'(o_Valid), int'(m_count != 0));
      chk("full", int'(o_Full), int'(m_count == DEPTH));
      chk("ovf", int'(o_Overflow), int'(m_ovf));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      chk("afull", int'(o_Almost_Full), int'(m_count >= DEPTH - 2));
`endif
      if (m_count == 0) begin
        chk("data_empty", int'(o_Data), 0);
      end
      if (i_Rd_En && o_Valid && i_Rst_n) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("pop_data", int'(o_Data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step(input bit dv, input logic [7:0] b,
                      input bit rd, input bit clr,
                      input bit rst = 1'b1);
    bit pop;
    bit full;
    bit push;
    bit drop;
    i_Rst_n   = rst;
    i_Rx_DV   = dv;
    i_Rx_Byte = b;
    i_Rd_En   = rd;
    i_Clr_Ovf = clr;
    pop  = rd && (m_count > 0);
    full = (m_count == DEPTH);
    push = dv && (!full || pop);
    drop = dv && full && !pop;
    if (!rst) exp_q.delete();
    else if (push) exp_q.push_back(b);
    @(posedge i_Clock);
    #1;
    if (!rst) begin
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      m_count = m_count + int'(push) - int'(pop);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge i_Clock);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    idle(1);

    // Single byte in and out.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_head", int'(o_Data), 'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Fill with 00..0F (wraps the write pointer), then drain.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_flag", int'(o_Full), 1);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Drop while full, clear, then clear during a drop.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("drop_ovf", int'(o_Overflow), 1);
    chk("drop_cnt", int'(o_Count), 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", int'(o_Overflow), 0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("set_wins", int'(o_Overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous write+pop: accepted, no overflow.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("wp_cnt", int'(o_Count), 16);
    chk("wp_ovf", int'(o_Overflow), 0);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Pop on empty is ignored.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Sustained write+pop at one entry of occupancy.
    step(1'b1, 8'h40, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++)
      step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Reset with five bytes buffered.
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    chk("rst_cnt", int'(o_Count), 0);
    chk("rst_data", int'(o_Data), 0);
    idle(2);

    chk("sb_left", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte_fifo.md
# uart_rx_byte_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver state machine. Captures each byte the receiver flags as complete (one-cycle data-valid pulse) into a circular FIFO, so that a slower consumer such as the command decoder or a register bank can pop bytes at its own pace. Reports occupancy and full status, and sets a sticky flag when a received byte is lost because the FIFO was full.

## Interface
- DEPTH, 16: number of byte entries; power of two, ≥ 2.
- AF_LEVEL, DEPTH-2: almost-full threshold; only used with `UART_RX_FIFO_ALMOST_FULL_EN`.

- i_Clock  in  1  single system clock; all logic on its rising edge.
- i_Rst_n  in  1  reset; synchronous, active-low.
- i_Rx_DV  in  1  one-cycle pulse from the receiver: i_Rx_Byte is valid.
- i_Rx_Byte  in  8  received byte.
- i_Rd_En  in  1  consumer pop request.
- i_Clr_Ovf  in  1  clears o_Overflow.
- o_Data  out  8  head-of-FIFO byte (show-ahead); 8'h00 when empty.
- o_Valid  out  1  FIFO not empty.
- o_Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_Full  out  1  o_Count == DEPTH.
- o_Overflow  out  1  sticky: a byte was dropped.
- o_Almost_Full  out  1  only present with the macro.

## Operation
- Storage: DEPTH×8 register array; write pointer and read pointer, each $clog2(DEPTH) bits, with natural wrap DEPTH-1 → 0. A separate count register drives o_Count, o_Full and o_Valid; full/empty are never derived from pointer equality alone.
- Write: on i_Rx_DV with space available (i.e. not full, or full with an accepted pop in the same cycle), store the byte at the write pointer and advance the pointer.
- Pop: accepted only when i_Rd_En && o_Valid; the read pointer advances. i_Rd_En while empty is ignored; pointers, count and flags do not change.
- Simultaneous write and pop: both are performed and the count is unchanged. This includes the full case, where the write is accepted and o_Overflow is not set.
- Drop: i_Rx_DV while full with no accepted pop. The byte is discarded, pointers and count are unchanged, and o_Overflow is set.
- o_Overflow: when set and clear occur in the same cycle, set wins. Once set, it stays set until i_Clr_Ovf or reset.
- o_Data is a combinational read of the entry at the read pointer, gated to 8'h00 when o_Valid=0.
- Reset (i_Rst_n=0 at an edge):
  - pointers and count go to 0, so o_Valid=0, o_Full=0, o_Count=0, o_Data=8'h00;
  - o_Overflow=0 and o_Almost_Full=0;
  - array contents are not reset;
  - reset overrides any concurrent write or pop;
  - reset in mid-stream discards all buffered bytes.

## Timing
- Write latency: a byte with i_Rx_DV at edge N appears on o_Data, with o_Valid=1, in the cycle after edge N (if the FIFO was empty).
- Pop: after an accepted pop at edge N, o_Data shows the next entry in the following cycle. o_Count, o_Full and o_Valid all update at the same edge.
- Throughput: one write and one pop per cycle, sustained.
- o_Overflow asserts in the cycle after the edge on which the drop occurred.

## Configuration
- `UART_RX_FIFO_ALMOST_FULL_EN` defined:
  - o_Almost_Full port exists.
  - It is registered from next-state count, so it equals (o_Count ≥ AF_LEVEL) on the same cycle as o_Count.
  - Intended for RTS-style flow control.
- Macro not defined: the port and its logic are absent; everything else is identical.

## Test plan
- Reset, then write 8'hA5 → next cycle: o_Valid=1, o_Data=8'hA5, o_Count=1. Pop → o_Valid=0, o_Data=8'h00.
- Write DEPTH bytes 8'h00..8'h0F with no pops → o_Full=1, o_Count=16. Pop 16 times → same order out, with pointer wrap exercised.
- FIFO full, write 8'hEE with no pop → byte dropped, o_Overflow=1, count stays 16. Pulse i_Clr_Ovf → 0. Assert i_Clr_Ovf during a second drop → o_Overflow stays 1.
- FIFO full, write 8'h77 and pop in the same cycle → o_Count stays 16, o_Overflow=0, and 8'h77 appears last on readout.
- Pop while empty → no change. Assert reset with 5 bytes buffered → all outputs return to reset values.
- With the macro and AF_LEVEL=14 → o_Almost_Full rises in the same cycle o_Count becomes 14, and falls when it returns to 13.
